// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and latency sequencer for a byte-wide synchronous memory port.
// Define MEM_BUS_ARBITER_STATS_EN to add saturating grant/stall statistics outputs.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SIZE_W      = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MEM_SIZE    = 1,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_oe,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SIZE_W-1:0] m0_size,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_data_rdy,
  input  logic              m1_oe,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [SIZE_W-1:0] m1_size,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_data_rdy,
  output logic              s_oe,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [SIZE_W-1:0] s_size,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err_oor,
  output logic              err_proto
`ifdef MEM_BUS_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_grants0,
  output logic [31:0]       stat_grants1,
  output logic [31:0]       stat_stall
`endif
);

  localparam int unsigned AW1       = ADDR_W + 1;
  localparam int unsigned MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_DELAY - 1);
  localparam logic [AW1-1:0]   WIN_LO  = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0]   WIN_LEN = AW1'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                gnt_q;
  logic                we_q;
  logic                win_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                s_oe_q;
  logic                s_we_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [SIZE_W-1:0]   s_size_q;
  logic                rdy0_q;
  logic                rdy1_q;
  logic                err_oor_q;
  logic [DATA_W-1:0]   m0_rdata_q;
  logic [DATA_W-1:0]   m1_rdata_q;

  logic                elig0_c;
  logic                elig1_c;
  logic                req_c;
  logic                sel_c;
  logic                sel_we_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic [SIZE_W-1:0]   sel_size_c;
  logic [AW1-1:0]      offset_c;
  logic                win_c;
  logic [CNT_W-1:0]    load_cnt_c;
  logic [DATA_W-1:0]   resp_data_c;

  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_W; i++) m[i] = (i < 32'(sz));
    return m;
  endfunction

  // Request decode, round-robin pick and window check on the widened offset
  always_comb begin
    elig0_c     = m0_oe ^ m0_we;
    elig1_c     = m1_oe ^ m1_we;
    req_c       = elig0_c | elig1_c;
    sel_c       = (elig0_c & elig1_c) ? ~last_grant_q : elig1_c;
    sel_we_c    = sel_c ? m1_we    : m0_we;
    sel_addr_c  = sel_c ? m1_addr  : m0_addr;
    sel_wdata_c = sel_c ? m1_wdata : m0_wdata;
    sel_size_c  = sel_c ? m1_size  : m0_size;
    // A borrow sets the top bit, so addresses below the base never alias into the window
    offset_c    = {1'b0, sel_addr_c} - WIN_LO;
    win_c       = ~offset_c[ADDR_W] && (offset_c < WIN_LEN);
    load_cnt_c  = we_q ? WR_CNT : RD_CNT;
    resp_data_c = (!we_q && win_q) ? s_rdata : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      win_q        <= 1'b0;
      cnt_q        <= '0;
      s_oe_q       <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_size_q     <= '0;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      err_oor_q    <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      s_oe_q    <= 1'b0;
      s_we_q    <= 1'b0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      err_oor_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_c) begin
            gnt_q        <= sel_c;
            last_grant_q <= sel_c;
            we_q         <= sel_we_c;
            win_q        <= win_c;
            s_oe_q       <= win_c & ~sel_we_c;
            s_we_q       <= win_c & sel_we_c;
            s_addr_q     <= offset_c[ADDR_W-1:0];
            s_wdata_q    <= sel_wdata_c & size_mask(sel_size_c);
            s_size_q     <= sel_size_c;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= load_cnt_c;
          if (load_cnt_c == '0) begin
            rdy0_q    <= ~gnt_q;
            rdy1_q    <= gnt_q;
            err_oor_q <= ~win_q;
            state_q   <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdy0_q    <= ~gnt_q;
            rdy1_q    <= gnt_q;
            err_oor_q <= ~win_q;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (gnt_q) m1_rdata_q <= resp_data_c;
          else       m0_rdata_q <= resp_data_c;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data passes straight through in the response cycle, then is held
  always_comb begin
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
    if (state_q == RESP) begin
      if (gnt_q) m1_rdata = resp_data_c;
      else       m0_rdata = resp_data_c;
    end
  end

  assign m0_data_rdy = rdy0_q;
  assign m1_data_rdy = rdy1_q;
  assign s_oe        = s_oe_q;
  assign s_we        = s_we_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_size      = s_size_q;
  assign err_oor     = err_oor_q;
  assign err_proto   = ~reset & ((m0_oe & m0_we) | (m1_oe & m1_we));

`ifdef MEM_BUS_ARBITER_STATS_EN
  logic [31:0] grants0_q;
  logic [31:0] grants1_q;
  logic [31:0] stall_q;
  logic        grant0_c;
  logic        grant1_c;
  logic        stall_c;

  // A requester stalls when it is neither being granted nor already being served
  always_comb begin
    grant0_c = (state_q == IDLE) && req_c && !sel_c;
    grant1_c = (state_q == IDLE) && req_c && sel_c;
    stall_c  = (elig0_c && !(grant0_c || (state_q != IDLE && !gnt_q))) ||
               (elig1_c && !(grant1_c || (state_q != IDLE && gnt_q)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
      stall_q   <= '0;
    end else begin
      if (grant0_c && grants0_q != '1) grants0_q <= grants0_q + 32'd1;
      if (grant1_c && grants1_q != '1) grants1_q <= grants1_q + 32'd1;
      if (stall_c && stall_q != '1)    stall_q   <= stall_q + 32'd1;
    end
  end

  assign stat_grants0 = grants0_q;
  assign stat_grants1 = grants1_q;
  assign stat_stall   = stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a windowed instance (delays 2/1) and a READ_DELAY=4 instance for reset-in-WAIT.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned BASE   = 16;
  localparam int unsigned MSIZE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Instance A
  logic              rst;
  logic              m0_oe, m0_we, m1_oe, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [SIZE_W-1:0] m0_size, m1_size, s_size;
  logic              m0_data_rdy, m1_data_rdy, s_oe, s_we, err_oor, err_proto;

  // Instance B
  logic              rb;
  logic              b_m0_oe, b_m0_we, b_m1_oe, b_m1_we;
  logic [ADDR_W-1:0] b_m0_addr, b_m1_addr, b_s_addr;
  logic [DATA_W-1:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_s_wdata, b_s_rdata;
  logic [SIZE_W-1:0] b_m0_size, b_m1_size, b_s_size;
  logic              b_m0_data_rdy, b_m1_data_rdy, b_s_oe, b_s_we, b_err_oor, b_err_proto;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BASE_ADDR(BASE), .MEM_SIZE(MSIZE),
    .READ_DELAY(2), .WRITE_DELAY(1)
  ) u_dut (
    .clock(clk), .reset(rst),
    .m0_oe(m0_oe), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_rdata(m0_rdata), .m0_data_rdy(m0_data_rdy),
    .m1_oe(m1_oe), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_rdata(m1_rdata), .m1_data_rdy(m1_data_rdy),
    .s_oe(s_oe), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_size(s_size),
    .s_rdata(s_rdata), .err_oor(err_oor), .err_proto(err_proto)
  );

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BASE_ADDR(0), .MEM_SIZE(1),
    .READ_DELAY(4), .WRITE_DELAY(1)
  ) u_dut4 (
    .clock(clk), .reset(rb),
    .m0_oe(b_m0_oe), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_size(b_m0_size),
    .m0_rdata(b_m0_rdata), .m0_data_rdy(b_m0_data_rdy),
    .m1_oe(b_m1_oe), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_size(b_m1_size),
    .m1_rdata(b_m1_rdata), .m1_data_rdy(b_m1_data_rdy),
    .s_oe(b_s_oe), .s_we(b_s_we), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_size(b_s_size),
    .s_rdata(b_s_rdata), .err_oor(b_err_oor), .err_proto(b_err_proto)
  );

  // Memory for A: data appears exactly two cycles after the read strobe, 0xEE otherwise
  logic [7:0]        mem [4];
  logic [1:0]        rd_v;
  logic [ADDR_W-1:0] rd_a [2];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 8'h5A;
      mem[1] <= 8'h00;
      mem[2] <= 8'h00;
      mem[3] <= 8'h00;
      rd_v   <= 2'b00;
    end else begin
      rd_v    <= {rd_v[0], s_oe};
      rd_a[0] <= s_addr;
      rd_a[1] <= rd_a[0];
      if (s_we) mem[s_addr[1:0]] <= s_wdata;
    end
  end
  assign s_rdata   = rd_v[1] ? mem[rd_a[1][1:0]] : 8'hEE;
  assign b_s_rdata = 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit oe, input bit we, input int a, input int wd, input int sz);
    m0_oe = oe; m0_we = we; m0_addr = ADDR_W'(a); m0_wdata = DATA_W'(wd); m0_size = SIZE_W'(sz);
  endtask

  task automatic drive1(input bit oe, input bit we, input int a, input int wd, input int sz);
    m1_oe = oe; m1_we = we; m1_addr = ADDR_W'(a); m1_wdata = DATA_W'(wd); m1_size = SIZE_W'(sz);
  endtask

  initial begin
    rst = 1'b1; rb = 1'b1;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    b_m0_oe = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0; b_m0_size = '0;
    b_m1_oe = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0; b_m1_size = '0;
    repeat (3) tick();
    rst = 1'b0; rb = 1'b0;
    #1;
    chk("rst_s_oe", 32'(s_oe), 0);
    chk("rst_s_we", 32'(s_we), 0);
    chk("rst_rdy", 32'({m0_data_rdy, m1_data_rdy}), 0);
    chk("rst_err", 32'({err_oor, err_proto}), 0);
    chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
    chk("rst_s_bus", 32'({s_addr, s_wdata, s_size}), 0);
    tick();

    // m0 read at base: strobe at t+1, data_rdy with 0x5A at t+3
    drive0(1, 0, BASE, 0, 8);
    #1; chk("rd_t0_s_oe", 32'(s_oe), 0); tick();
    #1; chk("rd_t1_s_oe", 32'(s_oe), 1); chk("rd_t1_s_addr", 32'(s_addr), 0);
    chk("rd_t1_s_size", 32'(s_size), 8); tick();
    #1; chk("rd_t2_s_oe", 32'(s_oe), 0); chk("rd_t2_rdy", 32'(m0_data_rdy), 0); tick();
    #1; chk("rd_t3_rdy", 32'(m0_data_rdy), 1); chk("rd_t3_rdata", 32'(m0_rdata), 32'h5A);
    chk("rd_t3_err", 32'(err_oor), 0); chk("rd_t3_m1rdy", 32'(m1_data_rdy), 0); tick();
    drive0(0, 0, 0, 0, 0);
    #1; chk("rd_t4_rdy", 32'(m0_data_rdy), 0); chk("rd_t4_hold", 32'(m0_rdata), 32'h5A); tick();

    // m1 write 0xFF, size 4: masked to 0x0F, data_rdy at t+2
    drive1(0, 1, BASE, 8'hFF, 4);
    #1; tick();
    #1; chk("wr_t1_s_we", 32'(s_we), 1); chk("wr_t1_s_oe", 32'(s_oe), 0);
    chk("wr_t1_wdata", 32'(s_wdata), 32'h0F); chk("wr_t1_size", 32'(s_size), 4); tick();
    #1; chk("wr_t2_rdy", 32'(m1_data_rdy), 1); chk("wr_t2_rdata", 32'(m1_rdata), 0);
    chk("wr_t2_s_we", 32'(s_we), 0); chk("wr_t2_m0hold", 32'(m0_rdata), 32'h5A); tick();
    drive1(0, 0, 0, 0, 0);
    #1; chk("wr_t3_rdy", 32'(m1_data_rdy), 0); tick();

    // m0 write 0xA5 at base+3 (size 8), then m1 reads it back
    drive0(0, 1, BASE + 3, 8'hA5, 8);
    #1; tick();
    #1; chk("wr3_s_addr", 32'(s_addr), 3); chk("wr3_wdata", 32'(s_wdata), 32'hA5); tick();
    #1; chk("wr3_rdy", 32'(m0_data_rdy), 1); chk("wr3_rdata", 32'(m0_rdata), 0); tick();
    drive0(0, 0, 0, 0, 0);
    drive1(1, 0, BASE + 3, 0, 8);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rb3_rdy", 32'(m1_data_rdy), 32'(c == 3));
      if (c == 3) chk("rb3_rdata", 32'(m1_rdata), 32'hA5);
      tick();
    end
    drive1(0, 0, 0, 0, 0);
    #1; tick();

    // Both masters read continuously: m0, m1, m0, m1 every four cycles
    drive0(1, 0, BASE, 0, 8);
    drive1(1, 0, BASE + 3, 0, 8);
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("rr_s_oe", 32'(s_oe), 32'(c % 4 == 1));
      chk("rr_m0_rdy", 32'(m0_data_rdy), 32'(c == 3 || c == 11));
      chk("rr_m1_rdy", 32'(m1_data_rdy), 32'(c == 7 || c == 15));
      chk("rr_excl", 32'(m0_data_rdy & m1_data_rdy), 0);
      if (c % 4 == 1) chk("rr_s_addr", 32'(s_addr), 32'((c == 1 || c == 9) ? 0 : 3));
      if (c == 3 || c == 11) chk("rr_m0_rdata", 32'(m0_rdata), 32'h0F);
      if (c == 7 || c == 15) chk("rr_m1_rdata", 32'(m1_rdata), 32'hA5);
      tick();
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    #1; chk("rr_end_rdy", 32'({m0_data_rdy, m1_data_rdy}), 0); tick();

    // m0 read one past the window: no strobe, rdata 0 with err_oor at t+3
    drive0(1, 0, BASE + MSIZE, 0, 8);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("oor_s_oe", 32'(s_oe), 0);
      chk("oor_rdy", 32'(m0_data_rdy), 32'(c == 3));
      chk("oor_err", 32'(err_oor), 32'(c == 3));
      if (c == 3) chk("oor_rdata", 32'(m0_rdata), 0);
      tick();
    end
    drive0(0, 0, 0, 0, 0);
    #1; chk("oor_end_err", 32'(err_oor), 0); tick();

    // m1 write one below the window: no strobe, err_oor with data_rdy at t+2
    drive1(0, 1, BASE - 1, 8'h77, 8);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("oorw_s_we", 32'(s_we), 0);
      chk("oorw_rdy", 32'(m1_data_rdy), 32'(c == 2));
      chk("oorw_err", 32'(err_oor), 32'(c == 2));
      if (c == 2) chk("oorw_rdata", 32'(m1_rdata), 0);
      tick();
    end
    drive1(0, 0, 0, 0, 0);
    #1; tick();

    // m0 holds oe&we: err_proto every cycle, never served; m1 read meanwhile served
    drive0(1, 1, BASE, 8'h11, 8);
    for (int p = 0; p < 8; p++) begin
      if (p == 2) drive1(1, 0, BASE + 3, 0, 8);
      if (p == 6) drive1(0, 0, 0, 0, 0);
      #1;
      chk("pr_err", 32'(err_proto), 1);
      chk("pr_m0_rdy", 32'(m0_data_rdy), 0);
      chk("pr_s_we", 32'(s_we), 0);
      chk("pr_s_oe", 32'(s_oe), 32'(p == 3));
      chk("pr_m1_rdy", 32'(m1_data_rdy), 32'(p == 5));
      if (p == 5) chk("pr_m1_rdata", 32'(m1_rdata), 32'hA5);
      tick();
    end
    drive0(0, 0, 0, 0, 0);
    #1; chk("pr_end_err", 32'(err_proto), 0); tick();

    // Instance B, READ_DELAY=4: normal read has data_rdy at t+5
    b_m0_oe = 1'b1; b_m0_addr = '0; b_m0_size = 4'd8;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("b1_s_oe", 32'(b_s_oe), 32'(c == 1));
      chk("b1_rdy", 32'(b_m0_data_rdy), 32'(c == 5));
      if (c == 5) chk("b1_rdata", 32'(b_m0_rdata), 32'hC3);
      tick();
    end
    b_m0_oe = 1'b0;
    #1; tick();

    // Reset asserted in WAIT drops the transaction and clears outputs at once
    b_m0_oe = 1'b1;
    #1; tick();
    #1; chk("b2_issue_size", 32'(b_s_size), 8); tick();
    rb = 1'b1; b_m0_oe = 1'b0;
    #1;
    chk("b2_rst_rdata", 32'(b_m0_rdata), 0);
    chk("b2_rst_size", 32'(b_s_size), 0);
    chk("b2_rst_rdy", 32'(b_m0_data_rdy), 0);
    tick(); tick();
    rb = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("b2_post_rdy", 32'(b_m0_data_rdy), 0);
      chk("b2_post_s_oe", 32'(b_s_oe), 0);
      tick();
    end

    // Next request after reset has normal latency
    b_m0_oe = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("b3_s_oe", 32'(b_s_oe), 32'(c == 1));
      chk("b3_rdy", 32'(b_m0_data_rdy), 32'(c == 5));
      if (c == 5) chk("b3_rdata", 32'(b_m0_rdata), 32'hC3);
      tick();
    end
    b_m0_oe = 1'b0;
    #1; tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
